// File: rtl/mipi_dsi_pkg.sv
// Shared DSI video-controller definitions: data types, limits, FSM states and header helpers.
// Counter saturation also lives here.
package mipi_dsi_pkg;

  localparam logic [15:0] MAX_WC = 16'd7680;
  localparam int          ERR_W  = 8;

  localparam logic [5:0] DT_VSS     = 6'h01;
  localparam logic [5:0] DT_VSE     = 6'h11;
  localparam logic [5:0] DT_HSS     = 6'h21;
  localparam logic [5:0] DT_HSE     = 6'h31;
  localparam logic [5:0] DT_EOTP    = 6'h08;
  localparam logic [5:0] DT_NULL    = 6'h09;
  localparam logic [5:0] DT_BLANK   = 6'h19;
  localparam logic [5:0] DT_LONG_29 = 6'h29;
  localparam logic [5:0] DT_LONG_39 = 6'h39;
  localparam logic [5:0] DT_RGB888  = 6'h3E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PIX  = 2'd1,
    ST_SKIP = 2'd2
  } state_t;

  // Header word layout is {ECC[31:24], WC[23:8], DI[7:0]}; DT is DI[5:0], VC bits ignored.
  function automatic logic [5:0] hdr_dt(input logic [31:0] w);
    return w[5:0];
  endfunction

  function automatic logic [15:0] hdr_wc(input logic [31:0] w);
    return w[23:8];
  endfunction

  function automatic logic is_long_dt(input logic [5:0] dt);
    case (dt)
      DT_RGB888, DT_BLANK, DT_NULL, DT_LONG_29, DT_LONG_39: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mipi_dsi_video_ctrl_if.sv
// Slicer-to-controller word stream plus the video timing / pixel / error outputs.
interface mipi_dsi_video_ctrl_if;
  import mipi_dsi_pkg::*;

  logic [31:0]      din;
  logic             validin;
  logic             pktheader;
  logic             v_vsync;
  logic             v_hsync;
  logic [47:0]      v_pixel;
  logic [1:0]       v_pvalid;
  logic             v_line_end;
  logic [ERR_W-1:0] err_trunc;
  logic [ERR_W-1:0] err_align;
  logic [ERR_W-1:0] err_wc;

  modport master (
    output din, validin, pktheader,
    input  v_vsync, v_hsync, v_pixel, v_pvalid, v_line_end, err_trunc, err_align, err_wc
  );

  modport slave (
    input  din, validin, pktheader,
    output v_vsync, v_hsync, v_pixel, v_pvalid, v_line_end, err_trunc, err_align, err_wc
  );
endinterface

// File: rtl/mipi_pixel_gearbox.sv
// Repacks 0..4 payload bytes per word into 24-bit RGB pixels, up to two per clock.
// Keeps a 0..2 byte residual between words; earliest byte becomes R.
module mipi_pixel_gearbox (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        flush,
  input  logic        last,
  input  logic [2:0]  nbytes,
  input  logic [31:0] data,
  output logic [47:0] pixel,
  output logic [1:0]  pvalid,
  output logic        line_end,
  output logic        misalign
);

  logic [15:0] res_r;
  logic [1:0]  res_cnt_r;
  logic [47:0] comb_s;
  logic [2:0]  total_s;
  logic [1:0]  npix_s;
  logic [1:0]  rem_s;
  logic [15:0] nres_s;
  logic [23:0] pix0_s;
  logic [23:0] pix1_s;

  // Byte stream (residual first, little-endian by arrival) and pixel split
  always_comb begin
    case (res_cnt_r)
      2'd1:    comb_s = {8'h00, data, res_r[7:0]};
      2'd2:    comb_s = {data, res_r};
      default: comb_s = {16'h0000, data};
    endcase
    total_s = {1'b0, res_cnt_r} + nbytes;
    if (total_s >= 3'd6) begin
      npix_s = 2'd2;
    end else if (total_s >= 3'd3) begin
      npix_s = 2'd1;
    end else begin
      npix_s = 2'd0;
    end
    case (npix_s)
      2'd2: begin
        rem_s  = 2'(total_s - 3'd6);
        nres_s = 16'h0000;
      end
      2'd1: begin
        rem_s  = 2'(total_s - 3'd3);
        nres_s = comb_s[39:24];
      end
      default: begin
        rem_s  = total_s[1:0];
        nres_s = comb_s[15:0];
      end
    endcase
    pix0_s   = {comb_s[7:0],   comb_s[15:8],  comb_s[23:16]};
    pix1_s   = {comb_s[31:24], comb_s[39:32], comb_s[47:40]};
    misalign = en & ~flush & last & (rem_s != 2'd0);
  end

  // Residual state and registered pixel pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r     <= 16'h0000;
      res_cnt_r <= 2'd0;
      pixel     <= 48'h0;
      pvalid    <= 2'b00;
      line_end  <= 1'b0;
    end else begin
      pixel    <= 48'h0;
      pvalid   <= 2'b00;
      line_end <= 1'b0;
      if (flush) begin
        res_r     <= 16'h0000;
        res_cnt_r <= 2'd0;
      end else if (en) begin
        case (npix_s)
          2'd2: begin
            pvalid <= 2'b11;
            pixel  <= {pix1_s, pix0_s};
          end
          2'd1: begin
            pvalid <= 2'b01;
            pixel  <= {24'h000000, pix0_s};
          end
          default: pvalid <= 2'b00;
        endcase
        line_end <= last;
        if (last) begin
          res_r     <= 16'h0000;
          res_cnt_r <= 2'd0;
        end else begin
          res_r     <= nres_s;
          res_cnt_r <= rem_s;
        end
      end
    end
  end

endmodule

// File: rtl/mipi_dsi_video_ctrl.sv
// DSI RX sequencer: decodes packet headers, tracks payload byte accounting, emits sync pulses,
// feeds RGB888 payload to the pixel gearbox and keeps saturating protocol error counters.
module mipi_dsi_video_ctrl
  import mipi_dsi_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  mipi_dsi_video_ctrl_if.slave bus
);

  state_t           state_r;
  logic [16:0]      bytes_left_r;
  logic             vsync_r;
  logic             hsync_r;
  logic [ERR_W-1:0] err_trunc_r;
  logic [ERR_W-1:0] err_align_r;
  logic [ERR_W-1:0] err_wc_r;

  logic             hdr_s;
  logic             pay_s;
  logic [5:0]       dt_s;
  logic [15:0]      wc_s;
  logic             wc_ok_s;
  logic [2:0]       take_s;
  logic [16:0]      data_left_s;
  logic [2:0]       ndata_s;
  logic             last_s;
  logic             gb_en_s;
  logic             gb_flush_s;
  logic             gb_misalign_s;

  // Word classification and per-word byte accounting; the trailing 2 bytes of a payload are CRC
  always_comb begin
    hdr_s   = bus.validin & bus.pktheader;
    pay_s   = bus.validin & ~bus.pktheader & (state_r != ST_IDLE);
    dt_s    = hdr_dt(bus.din);
    wc_s    = hdr_wc(bus.din);
    wc_ok_s = (wc_s != 16'd0) && (wc_s <= MAX_WC);
    if (bytes_left_r >= 17'd4) begin
      take_s = 3'd4;
    end else begin
      take_s = bytes_left_r[2:0];
    end
    if (bytes_left_r > 17'd2) begin
      data_left_s = bytes_left_r - 17'd2;
    end else begin
      data_left_s = 17'd0;
    end
    if (data_left_s >= {14'd0, take_s}) begin
      ndata_s = take_s;
    end else begin
      ndata_s = data_left_s[2:0];
    end
    last_s     = (bytes_left_r <= 17'd4);
    gb_en_s    = pay_s & (state_r == ST_PIX);
    gb_flush_s = hdr_s & (state_r == ST_PIX);
  end

  mipi_pixel_gearbox u_gearbox (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (gb_en_s),
    .flush    (gb_flush_s),
    .last     (last_s),
    .nbytes   (ndata_s),
    .data     (bus.din),
    .pixel    (bus.v_pixel),
    .pvalid   (bus.v_pvalid),
    .line_end (bus.v_line_end),
    .misalign (gb_misalign_s)
  );

  // Packet FSM, sync pulses and saturating error counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      bytes_left_r <= 17'd0;
      vsync_r      <= 1'b0;
      hsync_r      <= 1'b0;
      err_trunc_r  <= {ERR_W{1'b0}};
      err_align_r  <= {ERR_W{1'b0}};
      err_wc_r     <= {ERR_W{1'b0}};
    end else begin
      vsync_r <= 1'b0;
      hsync_r <= 1'b0;
      if (gb_misalign_s) begin
        err_align_r <= sat_inc(err_align_r);
      end
      if (hdr_s) begin
        // A header inside a payload aborts that packet and is decoded on the spot
        if (state_r != ST_IDLE) begin
          err_trunc_r <= sat_inc(err_trunc_r);
        end
        if (is_long_dt(dt_s)) begin
          if (wc_ok_s) begin
            bytes_left_r <= {1'b0, wc_s} + 17'd2;
            state_r      <= (dt_s == DT_RGB888) ? ST_PIX : ST_SKIP;
          end else begin
            err_wc_r     <= sat_inc(err_wc_r);
            bytes_left_r <= 17'd0;
            state_r      <= ST_IDLE;
          end
        end else begin
          bytes_left_r <= 17'd0;
          state_r      <= ST_IDLE;
          vsync_r      <= (dt_s == DT_VSS);
          hsync_r      <= (dt_s == DT_HSS);
        end
      end else if (pay_s) begin
        case (state_r)
          ST_PIX, ST_SKIP: begin
            bytes_left_r <= bytes_left_r - {14'd0, take_s};
            if (last_s) begin
              state_r <= ST_IDLE;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.v_vsync   = vsync_r;
  assign bus.v_hsync   = hsync_r;
  assign bus.err_trunc = err_trunc_r;
  assign bus.err_align = err_align_r;
  assign bus.err_wc    = err_wc_r;

endmodule

// File: tb/tb_mipi_dsi_video_ctrl.sv
// Randomized self-checking bench for mipi_dsi_video_ctrl against a packet-level reference model.
module tb_mipi_dsi_video_ctrl;
  import mipi_dsi_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mipi_dsi_video_ctrl_if bus ();
  mipi_dsi_video_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int compared = 0;
  int mismatched = 0;
  logic [23:0] got_pix[$];
  logic [23:0] exp_pix[$];
  logic [7:0]  preset[$];
  int got_le, got_vs, got_hs, got_bad;
  int exp_le, exp_vs, exp_hs;
  int exp_trunc, exp_align, exp_wc;
  bit in_pkt;

  // Output monitor: pixels in arrival order plus pulse counts
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.v_pvalid[0]) got_pix.push_back(bus.v_pixel[23:0]);
      if (bus.v_pvalid[1]) got_pix.push_back(bus.v_pixel[47:24]);
      if (bus.v_pvalid == 2'b10) got_bad++;
      if (bus.v_line_end) got_le++;
      if (bus.v_vsync) got_vs++;
      if (bus.v_hsync) got_hs++;
    end
  end

  task automatic put(input bit hdr, input logic [31:0] w);
    @(negedge clk);
    bus.validin = 1'b1; bus.pktheader = hdr; bus.din = w;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.validin = 1'b0; bus.pktheader = 1'b0; bus.din = $urandom;
    end
  endtask

  task automatic clear_obs();
    got_pix.delete(); exp_pix.delete();
    got_le = 0; got_vs = 0; got_hs = 0; got_bad = 0;
    exp_le = 0; exp_vs = 0; exp_hs = 0;
  endtask

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Sends one packet (optionally cut after nw_lim payload words) and updates the reference model
  task automatic send_pkt(input logic [5:0] dt, input int wc, input int nw_lim, input bit gaps);
    logic [7:0]  bytes[$];
    logic [31:0] w;
    int nw_full, nw, nd;
    bit lng;
    lng = (dt == 6'h3E) || (dt == 6'h19) || (dt == 6'h09) || (dt == 6'h29) || (dt == 6'h39);
    if (in_pkt) exp_trunc++;
    in_pkt = 1'b0;
    put(1'b1, {8'($urandom), 16'(wc), 2'b00, dt});
    if (!lng) begin
      if (dt == 6'h01) exp_vs++;
      if (dt == 6'h21) exp_hs++;
    end else if (wc == 0 || wc > 7680) begin
      exp_wc++;
    end else begin
      for (int i = 0; i < wc + 2; i++)
        bytes.push_back((i < preset.size()) ? preset[i] : 8'($urandom));
      preset.delete();
      nw_full = (wc + 5) / 4;
      nw = (nw_lim < 0 || nw_lim >= nw_full) ? nw_full : nw_lim;
      for (int k = 0; k < nw; k++) begin
        if (gaps && $urandom_range(0, 3) == 0) idle(1);
        for (int b = 0; b < 4; b++)
          w[8*b +: 8] = (4*k + b < bytes.size()) ? bytes[4*k + b] : 8'($urandom);
        put(1'b0, w);
      end
      if (dt == 6'h3E) begin
        nd = (wc < 4*nw) ? wc : 4*nw;
        for (int p = 0; p < nd / 3; p++)
          exp_pix.push_back({bytes[3*p], bytes[3*p+1], bytes[3*p+2]});
        if (nw == nw_full) begin
          exp_le++;
          if (wc % 3 != 0) exp_align++;
        end
      end
      in_pkt = (nw != nw_full);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    compared++;
    if ({bus.v_vsync, bus.v_hsync, bus.v_pixel, bus.v_pvalid, bus.v_line_end} !== 53'd0) begin
      mismatched++; $display("FAIL reset_outputs got %h want 0", {bus.v_pvalid, bus.v_pixel});
    end
    compared++;
    if ({bus.err_trunc, bus.err_align, bus.err_wc} !== 24'd0) begin
      mismatched++; $display("FAIL reset_counters got %h want 0", {bus.err_trunc, bus.err_align, bus.err_wc});
    end
    rst_n = 1'b1;
    idle(2);
    compared++;
    if ({bus.v_vsync, bus.v_hsync, bus.v_pvalid, bus.v_line_end} !== 5'd0) begin
      mismatched++; $display("FAIL reset_release got %b want 0", {bus.v_vsync, bus.v_hsync, bus.v_pvalid, bus.v_line_end});
    end
  endtask

  task automatic test_sync();
    clear_obs();
    put(1'b1, 32'h0000_0001);
    idle(1);
    compared++;
    if (bus.v_vsync !== 1'b1 || bus.v_hsync !== 1'b0) begin
      mismatched++; $display("FAIL vsync_latency got vs=%b hs=%b want vs=1 hs=0", bus.v_vsync, bus.v_hsync);
    end
    put(1'b1, 32'h0000_0021);
    compared++;
    if (bus.v_vsync !== 1'b0) begin
      mismatched++; $display("FAIL vsync_width got %b want 0", bus.v_vsync);
    end
    idle(1);
    compared++;
    if (bus.v_hsync !== 1'b1 || bus.v_vsync !== 1'b0) begin
      mismatched++; $display("FAIL hsync_latency got vs=%b hs=%b want vs=0 hs=1", bus.v_vsync, bus.v_hsync);
    end
    idle(3);
    compared++;
    if (got_vs !== 1 || got_hs !== 1) begin
      mismatched++; $display("FAIL sync_counts got vs=%0d hs=%0d want 1 1", got_vs, got_hs);
    end
  endtask

  task automatic test_rgb_basic();
    clear_obs();
    send_pkt(6'h3E, 12, -1, 1'b0);
    put(1'b0, $urandom);
    send_pkt(6'h21, 0, -1, 1'b0);
    idle(4);
    compared++;
    if (got_pix.size() !== 4) begin
      mismatched++; $display("FAIL basic_npix got %0d want 4", got_pix.size());
    end
    foreach (exp_pix[i]) if (i < got_pix.size()) begin
      compared++;
      if (got_pix[i] !== exp_pix[i]) begin
        mismatched++; $display("FAIL basic_pix[%0d] got %h want %h", i, got_pix[i], exp_pix[i]);
      end
    end
    compared++;
    if (got_le !== 1 || got_hs !== 1 || bus.err_trunc !== 8'(sat8(exp_trunc))) begin
      mismatched++; $display("FAIL basic_end got le=%0d hs=%0d trunc=%0d want 1 1 %0d", got_le, got_hs, bus.err_trunc, exp_trunc);
    end
  endtask

  task automatic test_rgb_fixed();
    clear_obs();
    preset = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_pkt(6'h3E, 6, -1, 1'b0);
    idle(4);
    compared++;
    if (got_pix.size() !== 2) begin
      mismatched++; $display("FAIL fixed_npix got %0d want 2", got_pix.size());
    end else begin
      compared++;
      if (got_pix[0] !== 24'h112233 || got_pix[1] !== 24'h445566) begin
        mismatched++; $display("FAIL fixed_pix got %h %h want 112233 445566", got_pix[0], got_pix[1]);
      end
    end
    compared++;
    if (bus.err_align !== 8'(sat8(exp_align)) || bus.err_trunc !== 8'(sat8(exp_trunc)) || bus.err_wc !== 8'(sat8(exp_wc))) begin
      mismatched++; $display("FAIL fixed_errs got %0d %0d %0d want %0d %0d %0d", bus.err_align, bus.err_trunc, bus.err_wc, exp_align, exp_trunc, exp_wc);
    end
  endtask

  task automatic test_align();
    clear_obs();
    send_pkt(6'h3E, 7, -1, 1'b1);
    send_pkt(6'h3E, 9, -1, 1'b1);
    idle(4);
    compared++;
    if (got_pix.size() !== exp_pix.size()) begin
      mismatched++; $display("FAIL align_npix got %0d want %0d", got_pix.size(), exp_pix.size());
    end
    foreach (exp_pix[i]) if (i < got_pix.size()) begin
      compared++;
      if (got_pix[i] !== exp_pix[i]) begin
        mismatched++; $display("FAIL align_pix[%0d] got %h want %h", i, got_pix[i], exp_pix[i]);
      end
    end
    compared++;
    if (bus.err_align !== 8'(sat8(exp_align)) || got_le !== 2) begin
      mismatched++; $display("FAIL align_err got align=%0d le=%0d want %0d 2", bus.err_align, got_le, exp_align);
    end
  endtask

  task automatic test_trunc_wc();
    clear_obs();
    send_pkt(6'h19, 8, 1, 1'b0);
    send_pkt(6'h3E, 12, 2, 1'b0);
    send_pkt(6'h21, 0, -1, 1'b0);
    send_pkt(6'h3E, 0, -1, 1'b0);
    put(1'b0, $urandom);
    send_pkt(6'h39, 7681, -1, 1'b0);
    put(1'b0, $urandom);
    send_pkt(6'h29, 7680, -1, 1'b0);
    send_pkt(6'h3E, 15, -1, 1'b1);
    idle(4);
    compared++;
    if (got_pix.size() !== exp_pix.size()) begin
      mismatched++; $display("FAIL trunc_npix got %0d want %0d", got_pix.size(), exp_pix.size());
    end
    foreach (exp_pix[i]) if (i < got_pix.size()) begin
      compared++;
      if (got_pix[i] !== exp_pix[i]) begin
        mismatched++; $display("FAIL trunc_pix[%0d] got %h want %h", i, got_pix[i], exp_pix[i]);
      end
    end
    compared++;
    if (bus.err_trunc !== 8'(sat8(exp_trunc)) || bus.err_wc !== 8'(sat8(exp_wc))) begin
      mismatched++; $display("FAIL trunc_errs got trunc=%0d wc=%0d want %0d %0d", bus.err_trunc, bus.err_wc, exp_trunc, exp_wc);
    end
    compared++;
    if (got_hs !== exp_hs || got_le !== exp_le) begin
      mismatched++; $display("FAIL trunc_pulses got hs=%0d le=%0d want %0d %0d", got_hs, got_le, exp_hs, exp_le);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    for (int i = 0; i < 8; i++) begin
      send_pkt(6'h3E, $urandom_range(1, 30), -1, 1'b0);
      if (i == 3) send_pkt(6'h01, 0, -1, 1'b0);
    end
    idle(4);
    compared++;
    if (got_pix.size() !== exp_pix.size()) begin
      mismatched++; $display("FAIL b2b_npix got %0d want %0d", got_pix.size(), exp_pix.size());
    end
    foreach (exp_pix[i]) if (i < got_pix.size()) begin
      compared++;
      if (got_pix[i] !== exp_pix[i]) begin
        mismatched++; $display("FAIL b2b_pix[%0d] got %h want %h", i, got_pix[i], exp_pix[i]);
      end
    end
    compared++;
    if (got_le !== exp_le || got_vs !== exp_vs || bus.err_align !== 8'(sat8(exp_align)) || bus.err_trunc !== 8'(sat8(exp_trunc))) begin
      mismatched++; $display("FAIL b2b_counts got le=%0d vs=%0d align=%0d trunc=%0d want %0d %0d %0d %0d",
                             got_le, got_vs, bus.err_align, bus.err_trunc, exp_le, exp_vs, exp_align, exp_trunc);
    end
  endtask

  task automatic test_random();
    logic [5:0] dt;
    int wc, sel, nwl;
    clear_obs();
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 13);
      case (sel)
        0: dt = 6'h01;  1: dt = 6'h11;  2: dt = 6'h21;  3: dt = 6'h31;
        4: dt = 6'h08;  5: dt = 6'h19;  6: dt = 6'h09;  7: dt = 6'h29;
        8: dt = 6'h39;  9: dt = 6'($urandom_range(0, 63));
        default: dt = 6'h3E;
      endcase
      sel = $urandom_range(0, 9);
      wc = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(7681, 65535) : $urandom_range(1, 40);
      nwl = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 3) : -1;
      if (!in_pkt && $urandom_range(0, 4) == 0) put(1'b0, $urandom);
      send_pkt(dt, wc, nwl, 1'b1);
    end
    send_pkt(6'h31, 0, -1, 1'b0);
    idle(4);
    compared++;
    if (got_pix.size() !== exp_pix.size()) begin
      mismatched++; $display("FAIL rand_npix got %0d want %0d", got_pix.size(), exp_pix.size());
    end
    foreach (exp_pix[i]) if (i < got_pix.size()) begin
      compared++;
      if (got_pix[i] !== exp_pix[i]) begin
        mismatched++; $display("FAIL rand_pix[%0d] got %h want %h", i, got_pix[i], exp_pix[i]);
      end
    end
    compared++;
    if (got_le !== exp_le || got_vs !== exp_vs || got_hs !== exp_hs || got_bad !== 0) begin
      mismatched++; $display("FAIL rand_pulses got le=%0d vs=%0d hs=%0d bad=%0d want %0d %0d %0d 0",
                             got_le, got_vs, got_hs, got_bad, exp_le, exp_vs, exp_hs);
    end
    compared++;
    if (bus.err_trunc !== 8'(sat8(exp_trunc)) || bus.err_align !== 8'(sat8(exp_align)) || bus.err_wc !== 8'(sat8(exp_wc))) begin
      mismatched++; $display("FAIL rand_errs got %0d %0d %0d want %0d %0d %0d",
                             bus.err_trunc, bus.err_align, bus.err_wc, exp_trunc, exp_align, exp_wc);
    end
  endtask

  task automatic test_saturate();
    clear_obs();
    for (int i = 0; i < 300; i++) send_pkt(6'h3E, 0, -1, 1'b0);
    idle(2);
    compared++;
    if (bus.err_wc !== 8'(sat8(exp_wc))) begin
      mismatched++; $display("FAIL sat_err_wc got %0d want %0d", bus.err_wc, sat8(exp_wc));
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    put(1'b1, {8'h00, 16'd30, 8'h3E});
    put(1'b0, $urandom);
    put(1'b0, $urandom);
    @(negedge clk);
    rst_n = 1'b0;
    bus.validin = 1'b0; bus.pktheader = 1'b0;
    #1;
    compared++;
    if ({bus.v_vsync, bus.v_hsync, bus.v_pixel, bus.v_pvalid, bus.v_line_end} !== 53'd0 ||
        {bus.err_trunc, bus.err_align, bus.err_wc} !== 24'd0) begin
      mismatched++; $display("FAIL midreset_outputs got pv=%b wc=%0d want 0 0", bus.v_pvalid, bus.err_wc);
    end
    clear_obs();
    exp_trunc = 0; exp_align = 0; exp_wc = 0; in_pkt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_pkt(6'h3E, 9, -1, 1'b0);
    idle(4);
    compared++;
    if (got_pix.size() !== 3) begin
      mismatched++; $display("FAIL midreset_npix got %0d want 3", got_pix.size());
    end
    foreach (exp_pix[i]) if (i < got_pix.size()) begin
      compared++;
      if (got_pix[i] !== exp_pix[i]) begin
        mismatched++; $display("FAIL midreset_pix[%0d] got %h want %h", i, got_pix[i], exp_pix[i]);
      end
    end
    compared++;
    if (got_le !== 1 || bus.err_align !== 8'd0 || bus.err_trunc !== 8'd0) begin
      mismatched++; $display("FAIL midreset_clean got le=%0d align=%0d trunc=%0d want 1 0 0", got_le, bus.err_align, bus.err_trunc);
    end
  endtask

  initial begin
    bus.din = 32'h0; bus.validin = 1'b0; bus.pktheader = 1'b0;
    exp_trunc = 0; exp_align = 0; exp_wc = 0; in_pkt = 1'b0;
    clear_obs();
    test_reset();
    test_sync();
    test_rgb_basic();
    test_rgb_fixed();
    test_align();
    test_trunc_wc();
    test_back_to_back();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
